load_store_unit: RTL and testbench

Memory-stage load/store unit that sits directly upstream of the data cache. It accepts one load or store per handshake from the execute stage, computes the effective byte address, and drives the cache's word-addressed read/write port. Sub-word stores are handled with a read-modify-write sequence; sub-word loads are extracted and sign- or zero-extended. Misaligned or illegal requests are flagged without touching the cache.

---
 rtl/load_store_unit.sv | 150 +++++++++++++++
 tb/tb_load_store_unit.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Memory-stage load/store unit in front of a word-addressed data cache.
// Sub-word stores use read-modify-write; illegal or misaligned requests never touch the cache.
module load_store_unit #(
  parameter int XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic            i_is_load,
  input  logic            i_is_store,
  input  logic [2:0]      i_funct3,
  input  logic [XLEN-1:0] i_base,
  input  logic [XLEN-1:0] i_offset,
  input  logic [XLEN-1:0] i_store_data,
  input  logic [4:0]      i_rd,
  output logic            o_done,
  output logic [XLEN-1:0] o_load_data,
  output logic [4:0]      o_rd,
  output logic            o_exc,
  output logic            o_dc_r_en,
  output logic            o_dc_w_en,
  output logic [XLEN-1:0] o_dc_addr,
  output logic [XLEN-1:0] o_dc_wdata,
  input  logic [XLEN-1:0] i_dc_rdata
);

  typedef enum logic [2:0] {IDLE, ACCESS, MERGE_WR, DONE, EXC} state_t;

  state_t          state, state_next;
  logic [XLEN-1:0] ea_q, sdata_q, data_q;
  logic [2:0]      funct3_q;
  logic [4:0]      rd_q;
  logic            load_q;

  logic [XLEN-1:0] ea_in, lane, merged, extended, word_addr;
  logic            accept, bad_req;

  assign ea_in     = i_base + i_offset;
  assign accept    = i_valid && (state == IDLE);
  assign word_addr = {2'b00, ea_q[XLEN-1:2]};
  assign lane      = i_dc_rdata >> {ea_q[1:0], 3'b000};
  assign o_rd      = rd_q;

  // Request legality and alignment are judged on the raw inputs so the accept edge picks ACCESS or EXC.
  always_comb begin
    bad_req = 1'b0;
    if (i_is_load == i_is_store)
      bad_req = 1'b1;
    else if (i_is_load)
      bad_req = (i_funct3 == 3'b011) || (i_funct3[2:1] == 2'b11);
    else
      bad_req = (i_funct3 >= 3'b011);
    case (i_funct3[1:0])
      2'b01:   if (ea_in[0]) bad_req = 1'b1;
      2'b10:   if (ea_in[1:0] != 2'b00) bad_req = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    merged = i_dc_rdata;
    if (funct3_q[0])
      merged[{ea_q[1], 4'b0000} +: 16] = sdata_q[15:0];
    else
      merged[{ea_q[1:0], 3'b000} +: 8] = sdata_q[7:0];
  end

  always_comb begin
    case (funct3_q)
      3'b000:  extended = {{(XLEN-8){data_q[7]}}, data_q[7:0]};
      3'b001:  extended = {{(XLEN-16){data_q[15]}}, data_q[15:0]};
      3'b100:  extended = {{(XLEN-8){1'b0}}, data_q[7:0]};
      3'b101:  extended = {{(XLEN-16){1'b0}}, data_q[15:0]};
      default: extended = data_q;
    endcase
  end

  // data_q holds the selected load lane, or the merged word for a sub-word store.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state    <= IDLE;
      ea_q     <= '0;
      sdata_q  <= '0;
      data_q   <= '0;
      funct3_q <= '0;
      rd_q     <= '0;
      load_q   <= 1'b0;
    end else begin
      state <= state_next;
      if (accept) begin
        ea_q     <= ea_in;
        sdata_q  <= i_store_data;
        funct3_q <= i_funct3;
        rd_q     <= i_rd;
        load_q   <= i_is_load;
      end
      if (state == ACCESS)
        data_q <= load_q ? lane : merged;
    end
  end

  always_comb begin
    state_next  = state;
    o_ready     = 1'b0;
    o_done      = 1'b0;
    o_exc       = 1'b0;
    o_load_data = '0;
    o_dc_r_en   = 1'b0;
    o_dc_w_en   = 1'b0;
    o_dc_addr   = '0;
    o_dc_wdata  = '0;
    case (state)
      IDLE: begin
        o_ready = 1'b1;
        if (i_valid)
          state_next = bad_req ? EXC : ACCESS;
      end
      ACCESS: begin
        o_dc_addr = word_addr;
        if (!load_q && funct3_q == 3'b010) begin
          o_dc_w_en  = 1'b1;
          o_dc_wdata = sdata_q;
          state_next = DONE;
        end else begin
          o_dc_r_en  = 1'b1;
          state_next = load_q ? DONE : MERGE_WR;
        end
      end
      MERGE_WR: begin
        o_dc_addr  = word_addr;
        o_dc_w_en  = 1'b1;
        o_dc_wdata = data_q;
        state_next = DONE;
      end
      DONE: begin
        o_done      = 1'b1;
        o_load_data = load_q ? extended : '0;
        state_next  = IDLE;
      end
      EXC: begin
        o_done     = 1'b1;
        o_exc      = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a small word memory standing in for the data cache.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid, ready, is_load, is_store;
  logic [2:0]  funct3;
  logic [31:0] base, offset, store_data;
  logic [4:0]  rd, rd_out;
  logic        done, exc, dc_r_en, dc_w_en;
  logic [31:0] load_data, dc_addr, dc_wdata, dc_rdata;
  logic [31:0] mem [0:255];

  int checkCount = 0;
  int errorCount = 0;

  always #5 clk = ~clk;

  load_store_unit #(.XLEN(32)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .o_ready(ready),
    .i_is_load(is_load), .i_is_store(is_store), .i_funct3(funct3),
    .i_base(base), .i_offset(offset), .i_store_data(store_data), .i_rd(rd),
    .o_done(done), .o_load_data(load_data), .o_rd(rd_out), .o_exc(exc),
    .o_dc_r_en(dc_r_en), .o_dc_w_en(dc_w_en), .o_dc_addr(dc_addr),
    .o_dc_wdata(dc_wdata), .i_dc_rdata(dc_rdata)
  );

  assign dc_rdata = mem[dc_addr[7:0]];

  always @(posedge clk)
    if (dc_w_en) mem[dc_addr[7:0]] <= dc_wdata;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
    end
  endtask

  // Waits (bounded) for an IDLE cycle, presents the request, and returns 1 time unit after the accept edge.
  task automatic applyStimulus(input logic ld, input logic st, input logic [2:0] f3,
                               input logic [31:0] b, input logic [31:0] off,
                               input logic [31:0] data, input logic [4:0] dest);
    int waited = 0;
    @(negedge clk);
    while (!ready && waited < 8) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("ready_before_accept", 32'(ready), 1);
    valid = 1'b1; is_load = ld; is_store = st; funct3 = f3;
    base = b; offset = off; store_data = data; rd = dest;
    @(posedge clk);
    #1;
    valid = 1'b0; is_load = 1'b0; is_store = 1'b0; funct3 = 3'b111;
    base = 32'hA5A5A5A5; offset = 32'h5A5A5A5A; store_data = 32'h0; rd = 5'd31;
  endtask

  task automatic doStoreWord(input string tag, input logic [31:0] b, input logic [31:0] off,
                             input logic [31:0] data, input logic [31:0] exp_addr);
    applyStimulus(1'b0, 1'b1, 3'b010, b, off, data, 5'd0);
    checkOutput({tag, " w_en"}, 32'(dc_w_en), 1);
    checkOutput({tag, " r_en"}, 32'(dc_r_en), 0);
    checkOutput({tag, " addr"}, dc_addr, exp_addr);
    checkOutput({tag, " wdata"}, dc_wdata, data);
    checkOutput({tag, " ready_busy"}, 32'(ready), 0);
    @(posedge clk); #1;
    checkOutput({tag, " done"}, 32'(done), 1);
    checkOutput({tag, " exc"}, 32'(exc), 0);
    checkOutput({tag, " mem"}, mem[exp_addr[7:0]], data);
  endtask

  task automatic doLoad(input string tag, input logic [2:0] f3, input logic [31:0] off,
                        input logic [4:0] dest, input logic [31:0] expected);
    applyStimulus(1'b1, 1'b0, f3, 32'h100, off, 32'hFFFFFFFF, dest);
    checkOutput({tag, " r_en"}, 32'(dc_r_en), 1);
    checkOutput({tag, " w_en"}, 32'(dc_w_en), 0);
    checkOutput({tag, " addr"}, dc_addr, 32'h41);
    @(posedge clk); #1;
    checkOutput({tag, " done"}, 32'(done), 1);
    checkOutput({tag, " exc"}, 32'(exc), 0);
    checkOutput({tag, " data"}, load_data, expected);
    checkOutput({tag, " rd"}, 32'(rd_out), 32'(dest));
  endtask

  task automatic doSubStore(input string tag, input logic [2:0] f3, input logic [31:0] off,
                            input logic [31:0] data, input logic [31:0] merged);
    applyStimulus(1'b0, 1'b1, f3, 32'h100, off, data, 5'd0);
    checkOutput({tag, " read r_en"}, 32'(dc_r_en), 1);
    checkOutput({tag, " read w_en"}, 32'(dc_w_en), 0);
    checkOutput({tag, " read addr"}, dc_addr, 32'h41);
    @(posedge clk); #1;
    checkOutput({tag, " merge w_en"}, 32'(dc_w_en), 1);
    checkOutput({tag, " merge r_en"}, 32'(dc_r_en), 0);
    checkOutput({tag, " merge addr"}, dc_addr, 32'h41);
    checkOutput({tag, " merge wdata"}, dc_wdata, merged);
    checkOutput({tag, " merge done"}, 32'(done), 0);
    @(posedge clk); #1;
    checkOutput({tag, " done"}, 32'(done), 1);
    checkOutput({tag, " load_data"}, load_data, 0);
    checkOutput({tag, " mem"}, mem[8'h41], merged);
  endtask

  task automatic doException(input string tag, input logic ld, input logic st,
                             input logic [2:0] f3, input logic [31:0] off);
    applyStimulus(ld, st, f3, 32'h100, off, 32'h12345678, 5'd7);
    checkOutput({tag, " done"}, 32'(done), 1);
    checkOutput({tag, " exc"}, 32'(exc), 1);
    checkOutput({tag, " load_data"}, load_data, 0);
    checkOutput({tag, " r_en"}, 32'(dc_r_en), 0);
    checkOutput({tag, " w_en"}, 32'(dc_w_en), 0);
    @(posedge clk); #1;
    checkOutput({tag, " idle r_en"}, 32'(dc_r_en), 0);
    checkOutput({tag, " idle w_en"}, 32'(dc_w_en), 0);
    checkOutput({tag, " idle ready"}, 32'(ready), 1);
  endtask

  initial begin
    rst_n = 1'b0; valid = 1'b0; is_load = 1'b0; is_store = 1'b0; funct3 = 3'b000;
    base = '0; offset = '0; store_data = '0; rd = '0;
    #12;
    checkOutput("reset ready", 32'(ready), 1);
    checkOutput("reset done", 32'(done), 0);
    checkOutput("reset exc", 32'(exc), 0);
    checkOutput("reset r_en", 32'(dc_r_en), 0);
    checkOutput("reset w_en", 32'(dc_w_en), 0);
    checkOutput("reset addr", dc_addr, 0);
    checkOutput("reset wdata", dc_wdata, 0);
    checkOutput("reset load_data", load_data, 0);
    checkOutput("reset rd", 32'(rd_out), 0);
    @(negedge clk);
    rst_n = 1'b1;

    doStoreWord("sw_deadbeef", 32'h100, 32'h4, 32'hDEADBEEF, 32'h41);
    doStoreWord("sw_preload", 32'h100, 32'h4, 32'h80FF7F01, 32'h41);

    doLoad("lb_107", 3'b000, 32'h7, 5'd5, 32'hFFFFFF80);
    doLoad("lbu_107", 3'b100, 32'h7, 5'd6, 32'h00000080);
    doLoad("lh_104", 3'b001, 32'h4, 5'd9, 32'h00007F01);
    doLoad("lhu_106", 3'b101, 32'h6, 5'd17, 32'h000080FF);
    doLoad("lh_106", 3'b001, 32'h6, 5'd18, 32'hFFFF80FF);
    doLoad("lw_104", 3'b010, 32'h4, 5'd31, 32'h80FF7F01);

    doSubStore("sb_105", 3'b000, 32'h5, 32'h123456AA, 32'h80FFAA01);
    // The halfword case starts again from the original word so its expected merge is 0xBEEF7F01.
    doStoreWord("sw_restore", 32'h100, 32'h4, 32'h80FF7F01, 32'h41);
    doSubStore("sh_106", 3'b001, 32'h6, 32'h0000BEEF, 32'hBEEF7F01);

    doException("lw_misaligned", 1'b1, 1'b0, 3'b010, 32'h2);
    doException("sh_misaligned", 1'b0, 1'b1, 3'b001, 32'h1);
    doException("load_f3_011", 1'b1, 1'b0, 3'b011, 32'h4);
    doException("load_and_store", 1'b1, 1'b1, 3'b010, 32'h4);
    doException("neither_op", 1'b0, 1'b0, 3'b010, 32'h4);
    doException("store_f3_100", 1'b0, 1'b1, 3'b100, 32'h4);

    doStoreWord("sw_wrap", 32'hFFFFFFFC, 32'h8, 32'h11223344, 32'h1);

    // Reset lands during the write-back cycle of a byte store: the write must vanish at once.
    applyStimulus(1'b0, 1'b1, 3'b000, 32'h100, 32'h4, 32'h00000055, 5'd0);
    @(posedge clk); #1;
    checkOutput("rst_mid w_en_before", 32'(dc_w_en), 1);
    checkOutput("rst_mid wdata_before", dc_wdata, 32'hBEEF7F55);
    rst_n = 1'b0;
    #1;
    checkOutput("rst_mid w_en", 32'(dc_w_en), 0);
    checkOutput("rst_mid ready", 32'(ready), 1);
    checkOutput("rst_mid done", 32'(done), 0);
    checkOutput("rst_mid addr", dc_addr, 0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    checkOutput("rst_mid mem", mem[8'h41], 32'hBEEF7F01);
    doLoad("lw_after_rst", 3'b010, 32'h4, 5'd3, 32'hBEEF7F01);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
